// File: rtl/toy_pack.sv
`default_nettype none
// ============================================================================
// Package : toy_pack
// Brief   : Shared BPU payload types for the RAS filter and the RAS itself.
// Rev     : 1.0 - initial release
// ============================================================================
package toy_pack;

  localparam int ADDR_WIDTH  = 32;
  localparam int FETCH_SLOTS = 8;
  localparam int SLOT_W      = $clog2(FETCH_SLOTS);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pred_pc;
    logic [ADDR_WIDTH-1:0]  tgt_pc;
    logic [SLOT_W-1:0]      offset;
    logic [1:0]             inst_type;
    logic                   taken;
    logic                   is_cext;
    logic                   carry;
  } ras_pkg;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  pred_pc;
    logic [ADDR_WIDTH-1:0]  tgt_pc;
    logic                   taken;
    logic [SLOT_W-1:0]      taken_slot;
    logic                   carry;
    logic [FETCH_SLOTS-1:0] slot_vld;
    logic [FETCH_SLOTS-1:0] slot_call;
    logic [FETCH_SLOTS-1:0] slot_ret;
    logic [FETCH_SLOTS-1:0] slot_cext;
  } ras_blk_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_DRAIN = 1'b1
  } ras_filt_state_e;

endpackage
`default_nettype wire

// File: rtl/toy_bpu_ras_filter_pick.sv
`default_nettype none
// ============================================================================
// Module : toy_bpu_ras_filter_pick
// Brief  : Lowest-set-bit priority encoder with one-hot and single-bit flag.
// Rev    : 1.0 - initial release
// ============================================================================
module toy_bpu_ras_filter_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o,
  output logic         only_one_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = W'(i);
    end
  end

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o   = req_i & (~req_i + N'(1));
  assign only_one_o = (req_i != '0) && ((req_i & (req_i - N'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/toy_bpu_ras_filter.sv
`default_nettype none
// ============================================================================
// Module : toy_bpu_ras_filter
// Brief  : Scans a predicted fetch block for call/ret slots and emits them
//          oldest first, one per cycle, toward the RAS.
// Rev    : 1.0 - initial release
// ============================================================================
module toy_bpu_ras_filter #(
  parameter int FETCH_SLOTS = toy_pack::FETCH_SLOTS,
  parameter int SLOT_W      = $clog2(FETCH_SLOTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pred_vld,
  output logic                pred_rdy,
  input  toy_pack::ras_blk_pkg pred_pld,
  input  logic                fe_ctrl_flush,
  output logic                filter_vld,
  output toy_pack::ras_pkg    filter_pld
);

  localparam int AW = toy_pack::ADDR_WIDTH;

  toy_pack::ras_filt_state_e state_q, state_d;
  logic [FETCH_SLOTS-1:0]    mask_q, mask_d;
  toy_pack::ras_blk_pkg      blk_q, blk_d;

  logic [FETCH_SLOTS-1:0]    limit;
  logic [FETCH_SLOTS-1:0]    cand;
  logic [SLOT_W-1:0]         pick_idx;
  logic [FETCH_SLOTS-1:0]    pick_onehot;
  logic                      pick_only_one;
  logic                      accept;
  logic [AW-1:0]             slot_pc;

  toy_bpu_ras_filter_pick #(
    .N (FETCH_SLOTS),
    .W (SLOT_W)
  ) u_pick (
    .req_i      (mask_q),
    .idx_o      (pick_idx),
    .onehot_o   (pick_onehot),
    .only_one_o (pick_only_one)
  );

  // Slots past the predicted-taken slot are never executed.
  always_comb begin
    limit = '0;
    for (int i = 0; i < FETCH_SLOTS; i++) begin
      limit[i] = !pred_pld.taken || (i <= int'(pred_pld.taken_slot));
    end
  end

  assign cand     = pred_pld.slot_vld & (pred_pld.slot_call | pred_pld.slot_ret) & limit;
  assign pred_rdy = !fe_ctrl_flush && ((mask_q == '0) || pick_only_one);
  assign accept   = pred_vld && pred_rdy;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    blk_d      = blk_q;
    filter_vld = 1'b0;
    case (state_q)
      toy_pack::RF_IDLE: begin
        if (accept && (cand != '0)) state_d = toy_pack::RF_DRAIN;
      end
      toy_pack::RF_DRAIN: begin
        filter_vld = 1'b1;
        mask_d     = mask_q & ~pick_onehot;
        if (pick_only_one) begin
          state_d = (accept && (cand != '0)) ? toy_pack::RF_DRAIN : toy_pack::RF_IDLE;
        end
      end
      default: state_d = toy_pack::RF_IDLE;
    endcase
    if (accept) begin
      blk_d  = pred_pld;
      mask_d = cand;
    end
    if (fe_ctrl_flush) begin
      mask_d  = '0;
      state_d = toy_pack::RF_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= toy_pack::RF_IDLE;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    blk_q <= blk_d;
  end

  assign slot_pc = blk_q.pc + {{(AW-SLOT_W-1){1'b0}}, pick_idx, 1'b0};

  always_comb begin
    filter_pld           = '0;
    filter_pld.pc        = slot_pc;
    filter_pld.pred_pc   = blk_q.pred_pc;
    filter_pld.offset    = pick_idx;
    filter_pld.inst_type = {blk_q.slot_ret[pick_idx], blk_q.slot_call[pick_idx]};
    filter_pld.is_cext   = blk_q.slot_cext[pick_idx];
    filter_pld.taken     = blk_q.taken && (pick_idx == blk_q.taken_slot);
    filter_pld.carry     = blk_q.carry;
    filter_pld.tgt_pc    = filter_pld.taken ? blk_q.tgt_pc
                         : slot_pc + (filter_pld.is_cext ? AW'(2) : AW'(4));
  end

endmodule
`default_nettype wire
